// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame geometry and receiver state encoding.
// Used by both the receive engine and the transmitter side.
package uart_pkg;

    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pad; 2 clk latency, resets to idle-high.
// No flow control: the output simply follows the input two edges later.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_fsm.sv
// 8N1 UART receiver on a 16x oversample enable; byte and framing-error pulses one clk after the stop sample.
// No backpressure: the consumer must take data_out on the cycle valid is high.
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int DATA_BITS  = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 sample_tick,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic rx_s;

    rx_state_e            state_q;
    logic [TICK_W-1:0]    tick_cnt_q;
    logic [TICK_W-1:0]    tick_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic [BIT_W-1:0]     bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic [DATA_BITS-1:0] data_out_q;
    logic                 valid_q;
    logic                 frame_err_q;
    logic                 busy_q;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    assign tick_cnt_d = tick_cnt_q + 1'b1;
    assign bit_cnt_d  = bit_cnt_q + 1'b1;
    // LSB arrives first, so after DATA_BITS shifts it has reached bit 0.
    assign shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q    <= START;
                        tick_cnt_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                START: begin
                    if (sample_tick) begin
                        if (tick_cnt_q == TICK_MID) begin
                            tick_cnt_q <= '0;
                            if (!rx_s) begin
                                state_q   <= DATA;
                                bit_cnt_q <= '0;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_d;
                        end
                    end
                end
                DATA: begin
                    if (sample_tick) begin
                        if (tick_cnt_q == TICK_LAST) begin
                            tick_cnt_q <= '0;
                            shift_q    <= shift_d;
                            bit_cnt_q  <= bit_cnt_d;
                            if (bit_cnt_q == BIT_LAST) begin
                                state_q <= STOP;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_d;
                        end
                    end
                end
                STOP: begin
                    if (sample_tick) begin
                        if (tick_cnt_q == TICK_LAST) begin
                            tick_cnt_q <= '0;
                            if (rx_s) begin
                                data_out_q <= shift_q;
                                valid_q    <= 1'b1;
                                state_q    <= IDLE;
                                busy_q     <= 1'b0;
                            end else begin
                                frame_err_q <= 1'b1;
                                state_q     <= WAIT_HIGH;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_d;
                        end
                    end
                end
                WAIT_HIGH: begin
                    // A held-low line (break) must not restart reception until it idles high.
                    if (sample_tick && rx_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = data_out_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: serial frames built from bit lists, results kept as a byte queue.
module tb_uart_rx_fsm;

    localparam int OS       = 16;
    localparam int TICK_DIV = 4;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       sample_tick;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int total;
    int bad;

    logic [7:0] got_q[$];
    int         ferr_n;
    int         both_n;
    bit         busy_seen;
    bit         tick_en;
    logic [7:0] last_good;

    uart_rx_fsm #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .sample_tick (sample_tick),
        .data_out    (data_out),
        .valid       (valid),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        int div;
        div         = 0;
        sample_tick = 1'b0;
        forever begin
            @(negedge clk);
            div         = (div + 1) % TICK_DIV;
            sample_tick = tick_en && (div == 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (valid) got_q.push_back(data_out);
                if (frame_err) ferr_n++;
                if (valid && frame_err) both_n++;
                if (busy) busy_seen = 1'b1;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_ticks(input int n);
        int guard;
        for (int i = 0; i < n; i++) begin
            guard = 0;
            do begin
                @(posedge clk);
                guard++;
            end while (!sample_tick && guard < 1000);
            if (!sample_tick) begin
                total++;
                bad++;
                $display("FAIL tick_wait got=no_tick want=tick");
                return;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        wait_ticks(OS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
    endtask

    task automatic clear_mon();
        got_q.delete();
        ferr_n    = 0;
        both_n    = 0;
        busy_seen = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total += 4;
        if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", data_out); end
        if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
        if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", frame_err); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        reset = 1'b0;
        wait_ticks(4);
        last_good = 8'h00;
    endtask

    task automatic test_single();
        clear_mon();
        send_frame(8'hA5, 1'b1);
        wait_ticks(2);
        last_good = 8'hA5;
        total += 5;
        if (got_q.size() != 1) begin bad++; $display("FAIL single_count got=%0d want=1", got_q.size()); end
        if (got_q.size() < 1 || got_q[0] !== 8'hA5) begin bad++; $display("FAIL single_byte got=%h want=a5", data_out); end
        if (ferr_n != 0) begin bad++; $display("FAIL single_ferr got=%0d want=0", ferr_n); end
        if (busy_seen !== 1'b1) begin bad++; $display("FAIL single_busy_seen got=%b want=1", busy_seen); end
        if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b want=0", busy); end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_ticks(2);
        last_good = 8'hFF;
        total += 4;
        if (got_q.size() != 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", got_q.size()); end
        if (got_q.size() < 1 || got_q[0] !== 8'h00) begin bad++; $display("FAIL b2b_first got=%h want=00", got_q.size() < 1 ? 8'hxx : got_q[0]); end
        if (got_q.size() < 2 || got_q[1] !== 8'hFF) begin bad++; $display("FAIL b2b_second got=%h want=ff", got_q.size() < 2 ? 8'hxx : got_q[1]); end
        if (ferr_n != 0) begin bad++; $display("FAIL b2b_ferr got=%0d want=0", ferr_n); end
    endtask

    task automatic test_glitch();
        clear_mon();
        rx = 1'b0;
        wait_ticks(3);
        rx = 1'b1;
        wait_ticks(OS);
        total += 3;
        if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy got=%b want=0", busy); end
        if (got_q.size() != 0) begin bad++; $display("FAIL glitch_valid got=%0d want=0", got_q.size()); end
        if (ferr_n != 0) begin bad++; $display("FAIL glitch_ferr got=%0d want=0", ferr_n); end
        send_frame(8'h3C, 1'b1);
        wait_ticks(2);
        last_good = 8'h3C;
        total += 2;
        if (got_q.size() != 1) begin bad++; $display("FAIL glitch_next_count got=%0d want=1", got_q.size()); end
        if (data_out !== 8'h3C) begin bad++; $display("FAIL glitch_next_byte got=%h want=3c", data_out); end
    endtask

    task automatic test_framing();
        clear_mon();
        send_frame(8'h55, 1'b0);
        wait_ticks(3 * OS);
        total += 1;
        if (busy !== 1'b1) begin bad++; $display("FAIL break_busy got=%b want=1", busy); end
        rx = 1'b1;
        wait_ticks(4);
        total += 4;
        if (ferr_n != 1) begin bad++; $display("FAIL break_ferr_count got=%0d want=1", ferr_n); end
        if (got_q.size() != 0) begin bad++; $display("FAIL break_valid got=%0d want=0", got_q.size()); end
        if (data_out !== last_good) begin bad++; $display("FAIL break_data got=%h want=%h", data_out, last_good); end
        if (busy !== 1'b0) begin bad++; $display("FAIL break_release got=%b want=0", busy); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        d = 8'h81;
        clear_mon();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx = d[4];
        wait_ticks(OS / 2);
        reset = 1'b1;
        @(negedge clk);
        total += 2;
        if (data_out !== 8'h00) begin bad++; $display("FAIL midrst_data got=%h want=00", data_out); end
        if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        repeat (3) @(negedge clk);
        rx    = 1'b1;
        reset = 1'b0;
        wait_ticks(20);
        total += 2;
        if (got_q.size() != 0) begin bad++; $display("FAIL midrst_valid got=%0d want=0", got_q.size()); end
        if (ferr_n != 0) begin bad++; $display("FAIL midrst_ferr got=%0d want=0", ferr_n); end
        send_frame(d, 1'b1);
        wait_ticks(2);
        last_good = d;
        total += 1;
        if (got_q.size() != 1 || got_q[0] !== 8'h81) begin bad++; $display("FAIL midrst_next got=%h want=81", data_out); end
    endtask

    task automatic test_tick_stall();
        logic [7:0] d;
        d = 8'h7E;
        clear_mon();
        rx = 1'b0;
        wait_ticks(4);
        tick_en = 1'b0;
        repeat (100) @(negedge clk);
        total += 2;
        if (busy !== 1'b1) begin bad++; $display("FAIL stall_busy got=%b want=1", busy); end
        if (got_q.size() != 0 || ferr_n != 0) begin bad++; $display("FAIL stall_output got=%0d/%0d want=0/0", got_q.size(), ferr_n); end
        tick_en = 1'b1;
        wait_ticks(OS - 4);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(1'b1);
        wait_ticks(2);
        last_good = d;
        total += 2;
        if (got_q.size() != 1 || got_q[0] !== 8'h7E) begin bad++; $display("FAIL stall_byte got=%h want=7e", data_out); end
        if (ferr_n != 0) begin bad++; $display("FAIL stall_ferr got=%0d want=0", ferr_n); end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        int         exp_err;
        logic [7:0] d;
        logic       stop_ok;
        clear_mon();
        exp_err = 0;
        for (int n = 0; n < 12; n++) begin
            d       = 8'($urandom_range(0, 255));
            stop_ok = ($urandom_range(0, 3) != 0);
            send_frame(d, stop_ok);
            rx = 1'b1;
            wait_ticks($urandom_range(2, 20));
            if (stop_ok) begin
                exp_q.push_back(d);
                last_good = d;
            end else begin
                exp_err++;
            end
        end
        total += 3;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        if (ferr_n != exp_err) begin bad++; $display("FAIL rand_ferr got=%0d want=%0d", ferr_n, exp_err); end
        if (both_n != 0) begin bad++; $display("FAIL rand_overlap got=%0d want=0", both_n); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_byte%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
        total++;
        if (data_out !== last_good) begin bad++; $display("FAIL rand_last got=%h want=%h", data_out, last_good); end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rx        = 1'b1;
        reset     = 1'b1;
        tick_en   = 1'b1;
        last_good = 8'h00;
        ferr_n    = 0;
        both_n    = 0;
        busy_seen = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_mid_frame();
        test_tick_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
